// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// IF stage of the RV32IM 5-stage pipeline. It owns the program counter and
// issues reads to the instruction memory. It applies branch/jump redirects
// from EX and load-use stalls from the hazard unit. It inserts NOP bubbles
// when a fetch is squashed, and it freezes the pipeline while the
// instruction memory is busy.
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//   NOP_INSTR  bubble instruction (addi x0,x0,0)
//
// Ports:
//   CLK              pipeline clock, all state updates on posedge
//   RESET            synchronous, active-high reset
//   BRANCH_TAKEN     redirect request from EX (overrides STALL)
//   BRANCH_TARGET    redirect address, bits [1:0] forced to zero
//   STALL            hazard-unit hold of PC and fetch
//   IMEM_READ        instruction memory read request
//   IMEM_ADDRESS     read address, always the PC register
//   IMEM_READDATA    fetched instruction, valid when IMEM_BUSYWAIT=0
//   IMEM_BUSYWAIT    memory not ready; address held stable meanwhile
//   OUT_PC           PC of OUT_INSTRUCTION, to IF/ID
//   OUT_INSTRUCTION  instruction or NOP_INSTR, to IF/ID
//   BUSYWAIT         pipeline freeze, to all pipeline registers
//
// Optional feature (macro FETCH_STALL_CNT_EN):
//   STALL_COUNT      saturating count of cycles with BUSYWAIT or STALL high
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        STALL,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] OUT_PC,
    output logic [31:0] OUT_INSTRUCTION,
    output logic        BUSYWAIT
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] STALL_COUNT
`endif
);

    typedef enum logic [1:0] {
        IDLE          = 2'b00,
        FETCH         = 2'b01,
        REDIRECT_WAIT = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pending_target;
    logic [31:0] pending_next;
    logic [31:0] branch_addr;
    logic        unused_target_bits;

    // Targets are word aligned; the low two bits are discarded.
    assign branch_addr        = {BRANCH_TARGET[31:2], 2'b00};
    assign unused_target_bits = ^BRANCH_TARGET[1:0];

    assign IMEM_ADDRESS = pc;
    assign OUT_PC       = pc;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            pending_target <= 32'h0000_0000;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            pending_target <= pending_next;
        end
    end

    // A redirect that arrives while a read is busy cannot abort that read,
    // so it is parked in pending_target. The returned data is discarded and
    // the PC jumps once memory is ready. The newest redirect always wins.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pending_next    = pending_target;
        IMEM_READ       = 1'b0;
        OUT_INSTRUCTION = NOP_INSTR;
        BUSYWAIT        = 1'b0;

        case (state)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                IMEM_READ       = 1'b1;
                BUSYWAIT        = IMEM_BUSYWAIT;
                OUT_INSTRUCTION = IMEM_READDATA;
                if (IMEM_BUSYWAIT) begin
                    if (BRANCH_TAKEN) begin
                        pending_next = branch_addr;
                        state_next   = REDIRECT_WAIT;
                    end
                end else if (BRANCH_TAKEN) begin
                    OUT_INSTRUCTION = NOP_INSTR;
                    pc_next         = branch_addr;
                end else if (!STALL) begin
                    pc_next = pc + 32'd4;
                end
            end

            REDIRECT_WAIT: begin
                IMEM_READ = 1'b1;
                BUSYWAIT  = IMEM_BUSYWAIT;
                if (BRANCH_TAKEN) begin
                    pending_next = branch_addr;
                end
                if (!IMEM_BUSYWAIT) begin
                    pc_next    = BRANCH_TAKEN ? branch_addr : pending_target;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef FETCH_STALL_CNT_EN
    // Each frozen or stalled cycle counts once; the counter sticks at all-ones.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            STALL_COUNT <= 32'h0000_0000;
        end else if ((BUSYWAIT || STALL) && (STALL_COUNT != 32'hFFFF_FFFF)) begin
            STALL_COUNT <= STALL_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Self-checking bench for instruction_fetch_unit. A table of per-cycle
// vectors with hand-derived expectations walks the directed scenarios. A short
// hand-written sequence covers a redirect that lands on the ready cycle.
// A randomized phase then compares every cycle against a behavioural model.
// When FETCH_STALL_CNT_EN is defined, STALL_COUNT is also checked against
// the model.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        STALL;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] OUT_PC;
    logic [31:0] OUT_INSTRUCTION;
    logic        BUSYWAIT;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] STALL_COUNT;
`endif

    instruction_fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .BRANCH_TAKEN   (BRANCH_TAKEN),
        .BRANCH_TARGET  (BRANCH_TARGET),
        .STALL          (STALL),
        .IMEM_READ      (IMEM_READ),
        .IMEM_ADDRESS   (IMEM_ADDRESS),
        .IMEM_READDATA  (IMEM_READDATA),
        .IMEM_BUSYWAIT  (IMEM_BUSYWAIT),
        .OUT_PC         (OUT_PC),
        .OUT_INSTRUCTION(OUT_INSTRUCTION),
        .BUSYWAIT       (BUSYWAIT)
`ifdef FETCH_STALL_CNT_EN
        ,
        .STALL_COUNT    (STALL_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] tgt;
        logic        st;
        logic [31:0] data;
        logic        busy;
        logic        e_read;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_bw;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model: a PC, whether fetching has started, and an optional
    // parked redirect target waiting for the busy read to finish.
    logic [31:0] m_pc;
    logic        m_active;
    logic        m_parked;
    logic [31:0] m_parked_tgt;
    logic [31:0] m_count;

    function automatic vec_t mk(logic rst, logic br, logic [31:0] tgt, logic st,
                                logic [31:0] data, logic busy, logic e_read,
                                logic [31:0] e_addr, logic [31:0] e_instr, logic e_bw);
        vec_t v;
        v.rst = rst; v.br = br; v.tgt = tgt; v.st = st; v.data = data; v.busy = busy;
        v.e_read = e_read; v.e_addr = e_addr; v.e_instr = e_instr; v.e_bw = e_bw;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        RESET         = v.rst;
        BRANCH_TAKEN  = v.br;
        BRANCH_TARGET = v.tgt;
        STALL         = v.st;
        IMEM_READDATA = v.data;
        IMEM_BUSYWAIT = v.busy;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_clock();
        logic [31:0] aligned;
        aligned = BRANCH_TARGET & 32'hFFFF_FFFC;
        if (RESET) begin
            m_pc = RESET_PC; m_active = 1'b0; m_parked = 1'b0; m_parked_tgt = 32'h0; m_count = 32'h0;
        end else begin
            if (((m_active && IMEM_BUSYWAIT) || STALL) && m_count != 32'hFFFF_FFFF)
                m_count = m_count + 1;
            if (!m_active) begin
                m_active = 1'b1;
            end else if (m_parked) begin
                if (BRANCH_TAKEN) m_parked_tgt = aligned;
                if (!IMEM_BUSYWAIT) begin
                    m_pc = m_parked_tgt;
                    m_parked = 1'b0;
                end
            end else if (IMEM_BUSYWAIT) begin
                if (BRANCH_TAKEN) begin
                    m_parked = 1'b1;
                    m_parked_tgt = aligned;
                end
            end else if (BRANCH_TAKEN) begin
                m_pc = aligned;
            end else if (!STALL) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_count(input string tag);
`ifdef FETCH_STALL_CNT_EN
        check_output({tag, " stall_count"}, STALL_COUNT, m_count);
`endif
    endtask

    // One cycle: drive, settle, compare against the vector, clock.
    task automatic run_vec(input string tag, input vec_t v);
        apply_stimulus(v);
        #1;
        check_output({tag, " imem_read"}, {31'h0, IMEM_READ}, {31'h0, v.e_read});
        check_output({tag, " imem_address"}, IMEM_ADDRESS, v.e_addr);
        check_output({tag, " out_pc"}, OUT_PC, v.e_addr);
        check_output({tag, " out_instruction"}, OUT_INSTRUCTION, v.e_instr);
        check_output({tag, " busywait"}, {31'h0, BUSYWAIT}, {31'h0, v.e_bw});
        check_count(tag);
        model_clock();
        @(posedge CLK);
        #1;
    endtask

    vec_t vecs[25];
    vec_t seq[3];

    initial begin
        vecs[0]  = mk(0,0,32'h0,0,32'h11,0,           0,32'h0,32'h13,0);
        vecs[1]  = mk(0,0,32'h0,0,32'h11,0,           1,32'h0,32'h11,0);
        vecs[2]  = mk(0,0,32'h0,0,32'h22,0,           1,32'h4,32'h22,0);
        vecs[3]  = mk(0,0,32'h0,0,32'hDEAD,1,         1,32'h8,32'hDEAD,1);
        vecs[4]  = mk(0,0,32'h0,0,32'hDEAD,1,         1,32'h8,32'hDEAD,1);
        vecs[5]  = mk(0,0,32'h0,0,32'hDEAD,1,         1,32'h8,32'hDEAD,1);
        vecs[6]  = mk(0,0,32'h0,0,32'h33,0,           1,32'h8,32'h33,0);
        vecs[7]  = mk(0,0,32'h0,0,32'h44,0,           1,32'hC,32'h44,0);
        vecs[8]  = mk(0,1,32'h103,0,32'h55,0,         1,32'h10,32'h13,0);
        vecs[9]  = mk(0,1,32'h20,0,32'h66,0,          1,32'h100,32'h13,0);
        vecs[10] = mk(0,1,32'h200,0,32'h77,1,         1,32'h20,32'h77,1);
        vecs[11] = mk(0,1,32'h300,0,32'h78,1,         1,32'h20,32'h13,1);
        vecs[12] = mk(0,0,32'h0,0,32'h79,1,           1,32'h20,32'h13,1);
        vecs[13] = mk(0,0,32'h0,0,32'h88,0,           1,32'h20,32'h13,0);
        vecs[14] = mk(0,1,32'h40,0,32'h99,0,          1,32'h300,32'h13,0);
        vecs[15] = mk(0,0,32'h0,1,32'hA1,0,           1,32'h40,32'hA1,0);
        vecs[16] = mk(0,0,32'h0,1,32'hA1,0,           1,32'h40,32'hA1,0);
        vecs[17] = mk(0,0,32'h0,0,32'hA1,0,           1,32'h40,32'hA1,0);
        vecs[18] = mk(0,1,32'hFFFF_FFFE,1,32'hA2,0,   1,32'h44,32'h13,0);
        vecs[19] = mk(0,0,32'h0,0,32'hA3,0,           1,32'hFFFF_FFFC,32'hA3,0);
        vecs[20] = mk(0,0,32'h0,0,32'hA4,0,           1,32'h0,32'hA4,0);
        vecs[21] = mk(0,0,32'h0,0,32'hA5,1,           1,32'h4,32'hA5,1);
        vecs[22] = mk(1,0,32'h0,0,32'hC0,1,           1,32'h4,32'hC0,1);
        vecs[23] = mk(0,0,32'h0,0,32'hB1,0,           0,32'h0,32'h13,0);
        vecs[24] = mk(0,0,32'h0,0,32'hB1,0,           1,32'h0,32'hB1,0);

        // Redirect parked during busy, then overridden on the ready cycle.
        seq[0] = mk(0,1,32'h500,0,32'hC1,1,           1,32'h4,32'hC1,1);
        seq[1] = mk(0,1,32'h600,0,32'hC2,0,           1,32'h4,32'h13,0);
        seq[2] = mk(0,0,32'h0,0,32'hC3,0,             1,32'h600,32'hC3,0);

        RESET = 1'b1; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
        STALL = 1'b0; IMEM_READDATA = 32'h0; IMEM_BUSYWAIT = 1'b0;
        m_pc = 32'h0; m_active = 1'b0; m_parked = 1'b0; m_parked_tgt = 32'h0; m_count = 32'h0;
        model_clock();
        @(posedge CLK);
        #1;

        for (int i = 0; i < 25; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
        for (int i = 0; i < 3; i++) run_vec($sformatf("seq%0d", i), seq[i]);

        // Randomized phase against the model.
        for (int c = 0; c < 400; c++) begin
            vec_t v;
            logic [31:0] e_instr;
            v.rst  = ($urandom_range(0, 49) == 0);
            v.br   = ($urandom_range(0, 6) == 0);
            v.tgt  = $urandom;
            v.st   = ($urandom_range(0, 4) == 0);
            v.data = $urandom;
            v.busy = ($urandom_range(0, 9) < 4);
            e_instr = (!m_active || m_parked || (v.br && !v.busy)) ? NOP_INSTR : v.data;
            v.e_read  = m_active;
            v.e_addr  = m_pc;
            v.e_instr = e_instr;
            v.e_bw    = m_active && v.busy;
            run_vec($sformatf("rand%0d", c), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
